prog_loader: RTL

Boot-time program loader that drives the write side of the CPU's instruction memory. The CPU only reads this memory; its write enable is tied low. The loader receives a framed byte stream from a host through a valid/ready handshake, assembles 16-bit instruction words and writes them from address 0 upward. It holds the CPU in reset until a complete frame with a correct checksum has been loaded.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 33 +++
 rtl/prog_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
//   state_e      - loader FSM states (IDLE..ERR)
//   SYNC_DEFAULT - frame start byte
//   WORD_W       - instruction word width shared with the instruction memory
package prog_loader_pkg;

    localparam int         WORD_W       = 16;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: host byte stream, instruction-memory write port and CPU boot status.
//   in_data/in_valid/in_ready - host byte stream (transfer = in_valid && in_ready)
//   im_we/im_add/im_din       - instruction memory write port
//   cpu_rst_n                 - active-low CPU reset, released after a verified load
//   busy/done/err             - frame in progress / last frame good / last frame bad
// master: the loader side; slave: the host, memory and CPU side.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = WORD_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_add;
    logic [DATA_W-1:0] im_din;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  in_data, in_valid,
        output in_ready, im_we, im_add, im_din, cpu_rst_n, busy, done, err
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, im_we, im_add, im_din, cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a framed, checksummed byte stream into instruction memory and
// holds the CPU in reset until a complete frame has been verified.
//   clk - clock
//   rst - asynchronous active-low reset
//   bus - prog_loader_if.master (host stream in, memory write port and status out)
// Frame: SYNC, LEN, 2*N data bytes (high byte first), CHK; N = LEN, or 256 when LEN = 0.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    prog_loader_if.master bus
);
    state_e            state_q, state_d;
    logic [7:0]        len_q, sum_q, hi_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [WORD_W-1:0] im_din_q;
    logic              in_ready_q, im_we_q, cpu_rst_n_q, busy_q, done_q, err_q;
    logic              xfer, is_sync, last;
    logic [7:0]        last_idx, chk_sum;

    assign xfer     = bus.in_valid && in_ready_q;
    assign is_sync  = xfer && bus.in_data == SYNC;
    // LEN = 0 wraps to 255 here, giving the 256-word frame without a 9-bit length.
    assign last_idx = len_q - 8'd1;
    assign last     = cnt_q == ADDR_W'(last_idx);
    assign chk_sum  = sum_q + bus.in_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: state_d = is_sync ? S_LEN : state_q;
            S_LEN:   state_d = xfer ? S_HI : S_LEN;
            S_HI:    state_d = xfer ? S_LO : S_HI;
            S_LO:    state_d = xfer ? S_WR : S_LO;
            S_WR:    state_d = last ? S_CHK : S_HI;
            S_CHK:   state_d = xfer ? (chk_sum == 8'd0 ? S_DONE : S_ERR) : S_CHK;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            im_din_q    <= '0;
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d != S_WR;
            im_we_q     <= state_d == S_WR;
            busy_q      <= state_d inside {S_LEN, S_HI, S_LO, S_WR, S_CHK};
            done_q      <= state_d == S_DONE;
            err_q       <= state_d == S_ERR;
            cpu_rst_n_q <= state_d == S_DONE;
            if (xfer && state_q == S_LEN) begin
                len_q <= bus.in_data;
                sum_q <= bus.in_data;
                cnt_q <= '0;
            end
            if (xfer && (state_q == S_HI || state_q == S_LO))
                sum_q <= chk_sum;
            if (xfer && state_q == S_HI)
                hi_q <= bus.in_data;
            if (xfer && state_q == S_LO)
                im_din_q <= {hi_q, bus.in_data};
            // Holds at the last address instead of wrapping.
            if (state_q == S_WR && !last)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.im_we     = im_we_q;
    assign bus.im_add    = cnt_q;
    assign bus.im_din    = im_din_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
